intc_nest_arb: RTL and testbench
================================

// Module: intc_nest_arb
// PURPOSE
//  Parametrised multi-source interrupt controller for the NES_SOC CPU. It latches
//  edge-triggered requests from NUM_SRC peripherals and arbitrates them by programmable priority.
//  It presents one vector/priority to the CPU control FSM with a req/ack handshake.
//  A hardware nesting stack of active priorities lets higher-priority sources pre-empt a running ISR.
// PARAMETERS
//  NUM_SRC    8      number of interrupt sources (2..32)
//  PRIO_W     3      priority width; 0 = never interrupts
//  VEC_W      8      vector width
//  VEC_BASE   8'h80  vector of source 0; source i -> VEC_BASE+i, modulo 2^VEC_W
//  NEST_DEPTH 4      nesting stack entries (1..8)
// PORTS
//  clk        in   1               clock, all state on rising edge
//  rst        in   1               synchronous reset, active-high
//  irq        in   NUM_SRC         raw request lines, rising edge = new request
//  cfg_we     in   1               write priority/enable of source cfg_idx
//  cfg_idx    in   $clog2(NUM_SRC) source index to configure
//  cfg_prio   in   PRIO_W          priority value written
//  cfg_en     in   1               enable bit written
//  cur_prio   in   PRIO_W          current PSR[10:8] priority of running code
//  int_req    out  1               interrupt request to CPU
//  int_vec    out  VEC_W           vector of requested source, valid while int_req
//  int_prio   out  PRIO_W          priority of requested source, valid while int_req
//  int_ack    in   1               CPU accepts request (1-cycle pulse)
//  int_eoi    in   1               CPU returns from ISR (1-cycle pulse)
//  pending    out  NUM_SRC         latched pending flags
//  nest_full  out  1               stack holds NEST_DEPTH entries
//  nest_err   out  1               1-cycle pulse: ack on full stack or eoi on empty stack
// BEHAVIOUR
//  Reset applies to every register when rst=1 at a clk edge.
//  - Reset state: pending=0, all prio=0, all en=0, irq history=0, stack empty, FSM IDLE.
//  - Reset outputs: int_req=0, int_vec=0, int_prio=0, nest_full=0, nest_err=0.
//  - Reset mid-handshake: drops int_req at the next edge and discards the stack.
//  Pending:
//  - pending[i] sets when irq[i]=1 and previous irq[i]=0. Level-high irq does not re-set pending.
//  - pending[i] clears on int_ack for the granted source.
//  - If set and clear hit the same source in one cycle, set wins.
//  - A disabled source still latches pending but is not eligible.
//  Arbitration (combinational, registered into FSM):
//  - Eligible = pending & en & prio>0. Winner = highest prio; ties go to lowest index.
//  - Threshold = max(cur_prio, stack top); stack top is 0 when the stack is empty.
//  - A request is raised only if winner prio > threshold (strict).
//  FSM IDLE/REQ:
//  - IDLE->REQ: on a qualifying winner. Winner and prio are captured into registers, so int_req rises 1 cycle after the pending edge.
//  - REQ: int_vec and int_prio are frozen, with no re-arbitration even if a higher source arrives.
//  - REQ->IDLE on int_ack: clear the captured source's pending, push int_prio, then drop int_req next cycle.
//  - REQ->IDLE without ack: if the captured source is disabled or lowered by cfg_we, or the threshold rises to >= int_prio.
//  - int_ack while IDLE is ignored.
//  Stack:
//  - int_eoi pops one entry. Pop on empty: no change, nest_err=1.
//  - ack with stack full: the ack is accepted but the push is dropped, nest_err=1, and the FSM still returns to IDLE.
//  - ack and eoi in the same cycle: pop first, then push, so depth is unchanged and top = new prio.
//  - Re-arbitration after ack or eoi uses the updated top, with a 1-cycle minimum gap before int_req.
//  Configuration: cfg_we takes effect the next cycle. A write with cfg_idx >= NUM_SRC is ignored.
// TESTING
//  1 Reset: rst=1 with irq=all-ones -> int_req=0, pending=0, nest_full=0.
//  2 Enable src3 prio5 and src1 prio5, edge both, cur_prio=2 -> int_req, vec=8'h81, prio=5 after 1 cycle.
//  3 Ack, then src6 prio7 edge -> push 5, then req vec=8'h86. Ack -> depth 2; eoi x2 -> empty.
//  4 cur_prio=4 with src2 prio4 pending -> no req. Set cur_prio=3 -> req vec=8'h82.
//  5 NEST_DEPTH=4, nest 4 ISRs then ack a 5th -> nest_err pulse and depth stays 4. eoi on empty -> nest_err.
//  6 While REQ for src0, disable src0 via cfg -> int_req falls, pending[0] stays 1. Edge on src0 while ack -> pending[0] stays 1.

Source files
------------

// File: rtl/intc_nest_arb.sv
`default_nettype none
// ============================================================================
//  Module      : intc_nest_arb
//  Description : Multi-source edge-triggered interrupt controller with
//                programmable priorities, a req/ack handshake toward the CPU
//                and a hardware nesting stack of active ISR priorities.
//  Revision    : 1.0  initial release
// ============================================================================
module intc_nest_arb #(
    parameter int               NUM_SRC    = 8,
    parameter int               PRIO_W     = 3,
    parameter int               VEC_W      = 8,
    parameter logic [VEC_W-1:0] VEC_BASE   = 8'h80,
    parameter int               NEST_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         irq,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_SRC)-1:0] cfg_idx,
    input  logic [PRIO_W-1:0]          cfg_prio,
    input  logic                       cfg_en,
    input  logic [PRIO_W-1:0]          cur_prio,
    output logic                       int_req,
    output logic [VEC_W-1:0]           int_vec,
    output logic [PRIO_W-1:0]          int_prio,
    input  logic                       int_ack,
    input  logic                       int_eoi,
    output logic [NUM_SRC-1:0]         pending,
    output logic                       nest_full,
    output logic                       nest_err
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int DW    = $clog2(NEST_DEPTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [NUM_SRC-1:0] r_irq_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_en;
    logic [PRIO_W-1:0]  r_prio  [NUM_SRC];
    logic [PRIO_W-1:0]  r_stack [NEST_DEPTH];
    logic [DW-1:0]      r_depth;
    logic [IDX_W-1:0]   r_idx;
    logic [VEC_W-1:0]   r_vec;
    logic [PRIO_W-1:0]  r_int_prio;
    logic               r_nest_err;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   w_win_idx;
    logic [PRIO_W-1:0]  w_win_prio;
    logic               w_win_ok;
    logic [PRIO_W-1:0]  w_top;
    logic [PRIO_W-1:0]  w_thr;
    logic               w_ack;
    logic               w_pop_ok;
    logic               w_push_ok;
    logic               w_err;
    logic [DW-1:0]      w_depth_mid;
    logic [DW-1:0]      w_depth_nxt;
    logic               w_drop;
    logic               w_go;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;

    // Arbiter: highest eligible priority wins, strict compare keeps the lowest index on ties
    always_comb begin
        w_win_idx  = '0;
        w_win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_pending[i] && r_en[i] && (r_prio[i] > w_win_prio)) begin
                w_win_prio = r_prio[i];
                w_win_idx  = IDX_W'(i);
            end
        end
    end

    // Stack top is the most recently pushed entry, or 0 when empty
    always_comb begin
        w_top = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (r_depth == DW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    assign w_thr    = (cur_prio > w_top) ? cur_prio : w_top;
    assign w_win_ok = (w_win_prio > w_thr);

    // Stack update: a same-cycle eoi pops before the ack pushes
    assign w_ack       = (r_state == S_REQ) && int_ack;
    assign w_pop_ok    = int_eoi && (r_depth != '0);
    assign w_depth_mid = w_pop_ok ? (r_depth - DW'(1)) : r_depth;
    assign w_push_ok   = w_ack && (w_depth_mid != DW'(NEST_DEPTH));
    assign w_depth_nxt = w_push_ok ? (w_depth_mid + DW'(1)) : w_depth_mid;
    assign w_err       = (int_eoi && (r_depth == '0)) || (w_ack && !w_push_ok);

    // A held request is withdrawn when its source is reconfigured away or masked by the threshold
    assign w_drop = !r_en[r_idx] || (r_prio[r_idx] < r_int_prio) || (w_thr >= r_int_prio);

    // An eoi cycle still sees the old stack top, so arbitration waits one cycle
    assign w_go = (r_state == S_IDLE) && w_win_ok && !int_eoi;

    assign w_set = irq & ~r_irq_d;
    assign w_clr = w_ack ? (NUM_SRC'(1) << r_idx) : '0;

    // Edge detection and pending latch; a new edge beats the ack clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_d   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_d   <= irq;
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Per-source priority/enable configuration; out-of-range indices match nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_prio[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    r_prio[i] <= cfg_prio;
                    r_en[i]   <= cfg_en;
                end
            end
        end
    end

    // Nesting stack of active ISR priorities and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth    <= '0;
            r_nest_err <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_depth    <= w_depth_nxt;
            r_nest_err <= w_err;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (w_push_ok && (w_depth_mid == DW'(i))) begin
                    r_stack[i] <= r_int_prio;
                end
            end
        end
    end

    // Request FSM: capture the winner, hold it frozen until ack or withdrawal
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_vec      <= '0;
            r_int_prio <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state    <= S_REQ;
                        r_idx      <= w_win_idx;
                        r_vec      <= VEC_BASE + VEC_W'(w_win_idx);
                        r_int_prio <= w_win_prio;
                    end
                end
                S_REQ: begin
                    if (int_ack || w_drop) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign int_req   = (r_state == S_REQ);
    assign int_vec   = int_req ? r_vec : '0;
    assign int_prio  = int_req ? r_int_prio : '0;
    assign pending   = r_pending;
    assign nest_full = (r_depth == DW'(NEST_DEPTH));
    assign nest_err  = r_nest_err;

endmodule
`default_nettype wire

// File: tb/tb_intc_nest_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intc_nest_arb
//  Description : Self-checking bench for intc_nest_arb; expected vector/priority
//                pairs are queued at stimulus time and compared when int_req rises.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_intc_nest_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [2:0] cfg_prio;
    logic       cfg_en;
    logic [2:0] cur_prio;
    logic       int_req;
    logic [7:0] int_vec;
    logic [2:0] int_prio;
    logic       int_ack;
    logic       int_eoi;
    logic [7:0] pending;
    logic       nest_full;
    logic       nest_err;

    typedef struct {
        logic [7:0] vec;
        logic [2:0] prio;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_req = 1'b0;

    intc_nest_arb #(
        .NUM_SRC   (8),
        .PRIO_W    (3),
        .VEC_W     (8),
        .VEC_BASE  (8'h80),
        .NEST_DEPTH(4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_prio (cfg_prio),
        .cfg_en   (cfg_en),
        .cur_prio (cur_prio),
        .int_req  (int_req),
        .int_vec  (int_vec),
        .int_prio (int_prio),
        .int_ack  (int_ack),
        .int_eoi  (int_eoi),
        .pending  (pending),
        .nest_full(nest_full),
        .nest_err (nest_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [2:0] pr, input logic en);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_prio = pr;
        cfg_en   = en;
        cyc(1);
        cfg_we   = 1'b0;
    endtask

    task automatic expect_req(input logic [7:0] v, input logic [2:0] p);
        exp_t e;
        e.vec  = v;
        e.prio = p;
        q.push_back(e);
    endtask

    task automatic edge_src(input int s);
        irq[s] = 1'b1;
        cyc(1);
        irq[s] = 1'b0;
    endtask

    task automatic ack;
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
    endtask

    task automatic eoi;
        int_eoi = 1'b1;
        cyc(1);
        int_eoi = 1'b0;
    endtask

    task automatic wait_req;
        int n = 0;
        while (!int_req && n < 20) begin
            cyc(1);
            n++;
        end
        chk("req_seen", 32'(int_req), 32'd1);
    endtask

    // Scoreboard: every rising int_req consumes one queued expectation
    always begin
        @(posedge clk);
        #2;
        if (int_req && !prev_req) begin
            if (q.size() == 0) begin
                chk("unexpected_req", 32'(int_req), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("int_vec", 32'(int_vec), 32'(e.vec));
                chk("int_prio", 32'(int_prio), 32'(e.prio));
            end
        end
        prev_req = int_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        irq      = 8'hFF;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_prio = '0;
        cfg_en   = 1'b0;
        cur_prio = '0;
        int_ack  = 1'b0;
        int_eoi  = 1'b0;

        // 1: reset with all requests high
        cyc(2);
        chk("rst_int_req", 32'(int_req), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_nest_full", 32'(nest_full), 32'd0);
        chk("rst_nest_err", 32'(nest_err), 32'd0);
        chk("rst_int_vec", 32'(int_vec), 32'd0);
        chk("rst_int_prio", 32'(int_prio), 32'd0);
        irq = 8'h00;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("idle_pending", 32'(pending), 32'd0);

        // 2: tie at prio 5 between src3 and src1, lowest index wins
        cfg(3'd3, 3'd5, 1'b1);
        cfg(3'd1, 3'd5, 1'b1);
        cfg(3'd6, 3'd7, 1'b1);
        cur_prio = 3'd2;
        expect_req(8'h81, 3'd5);
        irq = 8'h0A;
        cyc(1);
        irq = 8'h00;
        chk("t2_pending", 32'(pending), 32'h0A);
        chk("t2_req_lat0", 32'(int_req), 32'd0);
        cyc(1);
        chk("t2_req_lat1", 32'(int_req), 32'd1);

        // 3: nest src6 over src1, then unwind to src3
        ack;
        chk("t3_req_drop", 32'(int_req), 32'd0);
        chk("t3_pending", 32'(pending), 32'h08);
        cyc(2);
        chk("t3_no_req_tie_top", 32'(int_req), 32'd0);
        expect_req(8'h86, 3'd7);
        edge_src(6);
        cyc(1);
        chk("t3_src6_req", 32'(int_req), 32'd1);
        ack;
        chk("t3_full_d2", 32'(nest_full), 32'd0);
        eoi;
        cyc(2);
        chk("t3_no_req_d1", 32'(int_req), 32'd0);
        expect_req(8'h83, 3'd5);
        eoi;
        chk("t3_gap", 32'(int_req), 32'd0);
        chk("t3_eoi_err", 32'(nest_err), 32'd0);
        cyc(1);
        chk("t3_src3_req", 32'(int_req), 32'd1);
        ack;
        eoi;
        chk("t3_pending_clr", 32'(pending), 32'd0);

        // 4: strict threshold against cur_prio
        cur_prio = 3'd4;
        cfg(3'd2, 3'd4, 1'b1);
        edge_src(2);
        cyc(3);
        chk("t4_no_req", 32'(int_req), 32'd0);
        chk("t4_pending", 32'(pending), 32'h04);
        cur_prio = 3'd3;
        expect_req(8'h82, 3'd4);
        cyc(1);
        chk("t4_req", 32'(int_req), 32'd1);
        ack;
        eoi;
        cur_prio = 3'd0;

        // 5: fill the stack, overflow the ack, underflow the eoi
        for (int k = 0; k < 5; k++) begin
            cfg(3'(k), 3'(k + 1), 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            expect_req(8'h80 + 8'(k), 3'(k + 1));
            edge_src(k);
            wait_req;
            ack;
            chk("t5_ack_err", 32'(nest_err), (k == 4) ? 32'd1 : 32'd0);
            chk("t5_full", 32'(nest_full), (k >= 3) ? 32'd1 : 32'd0);
        end
        cyc(1);
        chk("t5_err_pulse_end", 32'(nest_err), 32'd0);
        for (int k = 0; k < 4; k++) begin
            eoi;
            chk("t5_pop_err", 32'(nest_err), 32'd0);
        end
        chk("t5_empty", 32'(nest_full), 32'd0);
        eoi;
        chk("t5_underflow_err", 32'(nest_err), 32'd1);
        ack;
        chk("t5_idle_ack_err", 32'(nest_err), 32'd0);
        eoi;
        chk("t5_idle_ack_no_push", 32'(nest_err), 32'd1);

        // 6: withdraw by disable, then edge coinciding with ack
        expect_req(8'h80, 3'd1);
        edge_src(0);
        wait_req;
        cfg(3'd0, 3'd1, 1'b0);
        chk("t6_req_hold", 32'(int_req), 32'd1);
        cyc(1);
        chk("t6_req_withdrawn", 32'(int_req), 32'd0);
        chk("t6_pending_kept", 32'(pending[0]), 32'd1);
        expect_req(8'h80, 3'd1);
        cfg(3'd0, 3'd1, 1'b1);
        wait_req;
        int_ack = 1'b1;
        irq[0]  = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        irq[0]  = 1'b0;
        chk("t6_set_wins", 32'(pending[0]), 32'd1);
        cyc(2);
        chk("t6_masked_by_top", 32'(int_req), 32'd0);
        expect_req(8'h80, 3'd1);
        eoi;
        wait_req;
        ack;
        eoi;
        chk("t6_pending_clr", 32'(pending), 32'd0);

        // Reset in the middle of a handshake
        expect_req(8'h80, 3'd1);
        edge_src(0);
        wait_req;
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_req", 32'(int_req), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_vec", 32'(int_vec), 32'd0);
        rst = 1'b0;
        cyc(2);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
